// File: rtl/writeback_regfile_pkg.sv
// Shared constants and types for the write-back / register-file slice.
// Optional feature macro: WB_FORWARD_EN (EX and WB bypass into the read ports).
package writeback_regfile_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned ADDR_W_DEF    = 5;
    localparam int unsigned REG_NUM       = 32;
    localparam logic [4:0]  REG_ZERO_ADDR = 5'd0;
    localparam logic [31:0] ZERO_WORD     = 32'h0;

    // Where a read port takes its value from.
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_EX    = 2'd1,
        SRC_WB    = 2'd2,
        SRC_ARRAY = 2'd3
    } rd_src_e;

endpackage

// File: rtl/writeback_regfile_array.sv
// Register file storage: one write port, two asynchronous read ports,
// asynchronous active-low clear of every entry, writes to $0 discarded.
module writeback_regfile_array
    import writeback_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              wr_en_s;

    // Suppress writes aimed at the hardwired zero register.
    always_comb begin
        wr_en_s = 1'b0;
        if (we && (waddr != {ADDR_W{1'b0}})) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage update: clear everything on reset, otherwise single-port write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata1 = mem_r[raddr1];
    assign rdata2 = mem_r[raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: EX/WB pipeline latch, commit into the register file and
// the two decode read ports ($0 reads as zero, reads are zero during reset).
// Optional macro WB_FORWARD_EN adds EX then WB bypass ahead of the array.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dest_addr_input,
    input  logic              write_or_not_input,
    input  logic [DATA_W-1:0] wdata_input,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              re1,
    input  logic              re2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_dest_addr,
    output logic              wb_write
);

    logic [ADDR_W-1:0] wb_dest_addr_r;
    logic              wb_write_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [DATA_W-1:0] arr_rdata1_s;
    logic [DATA_W-1:0] arr_rdata2_s;
    rd_src_e           src1_s;
    rd_src_e           src2_s;

    // Choose the source of one read port, youngest result first.
    function automatic rd_src_e pick_src(
        input logic              rst_v,
        input logic              re_v,
        input logic [ADDR_W-1:0] raddr_v,
        input logic              ex_we_v,
        input logic [ADDR_W-1:0] ex_addr_v,
        input logic              wb_we_v,
        input logic [ADDR_W-1:0] wb_addr_v
    );
        rd_src_e src;
        src = SRC_ZERO;
        if (!rst_v || !re_v) begin
            src = SRC_ZERO;
        end else if (raddr_v == {ADDR_W{1'b0}}) begin
            src = SRC_ZERO;
`ifdef WB_FORWARD_EN
        end else if (ex_we_v && (ex_addr_v == raddr_v)) begin
            src = SRC_EX;
        end else if (wb_we_v && (wb_addr_v == raddr_v)) begin
            src = SRC_WB;
`endif
        end else begin
            src = SRC_ARRAY;
        end
`ifndef WB_FORWARD_EN
        // Bypass operands only matter in the forwarding build.
        if (ex_we_v && wb_we_v && (ex_addr_v == wb_addr_v)) begin
            src = src;
        end else begin
            src = src;
        end
`endif
        return src;
    endfunction

    // EX/WB latch: flush beats stall, stall holds, otherwise capture EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_dest_addr_r <= {ADDR_W{1'b0}};
            wb_write_r     <= 1'b0;
            wb_data_r      <= {DATA_W{1'b0}};
        end else if (flush) begin
            wb_dest_addr_r <= {ADDR_W{1'b0}};
            wb_write_r     <= 1'b0;
            wb_data_r      <= {DATA_W{1'b0}};
        end else if (stall) begin
            wb_dest_addr_r <= wb_dest_addr_r;
            wb_write_r     <= wb_write_r;
            wb_data_r      <= wb_data_r;
        end else begin
            wb_dest_addr_r <= dest_addr_input;
            wb_write_r     <= write_or_not_input;
            wb_data_r      <= wdata_input;
        end
    end

    // Commit the latched result every cycle it is valid (repeats while stalled).
    writeback_regfile_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_write_r),
        .waddr  (wb_dest_addr_r),
        .wdata  (wb_data_r),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (arr_rdata1_s),
        .rdata2 (arr_rdata2_s)
    );

    // Source selection for both read ports.
    always_comb begin
        src1_s = SRC_ZERO;
        src2_s = SRC_ZERO;
        src1_s = pick_src(rst, re1, raddr1, write_or_not_input, dest_addr_input,
                          wb_write_r, wb_dest_addr_r);
        src2_s = pick_src(rst, re2, raddr2, write_or_not_input, dest_addr_input,
                          wb_write_r, wb_dest_addr_r);
    end

    // Read port 1 data mux.
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        case (src1_s)
            SRC_ZERO:  rdata1 = {DATA_W{1'b0}};
            SRC_EX:    rdata1 = wdata_input;
            SRC_WB:    rdata1 = wb_data_r;
            SRC_ARRAY: rdata1 = arr_rdata1_s;
            default:   rdata1 = {DATA_W{1'b0}};
        endcase
    end

    // Read port 2 data mux.
    always_comb begin
        rdata2 = {DATA_W{1'b0}};
        case (src2_s)
            SRC_ZERO:  rdata2 = {DATA_W{1'b0}};
            SRC_EX:    rdata2 = wdata_input;
            SRC_WB:    rdata2 = wb_data_r;
            SRC_ARRAY: rdata2 = arr_rdata2_s;
            default:   rdata2 = {DATA_W{1'b0}};
        endcase
    end

    assign wb_dest_addr = wb_dest_addr_r;
    assign wb_write     = wb_write_r;

endmodule
